// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer
// Continuous round-robin scanner for an ADC128S022-style 4-wire SPI ADC.
// It drives CS/SCLK/DIN itself (SCLK = clk/2) and deserialises DOUT.
// It keeps one 12-bit result per channel and raises a one-cycle scan_done
// when a full set of channels has been refreshed.
// The ADC converts the channel addressed in the previous frame. Because of
// that, the first frame after IDLE only primes the pipeline and its data is
// dropped.

module adc_scan_sequencer #(
  parameter int unsigned NUM_CH  = 4,
  parameter logic [11:0] THRESH  = 12'd2048,
  parameter int unsigned GAP_CYC = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  output logic                    sclk,
  output logic                    cs,
  output logic                    din,
  input  logic                    dout,
  output logic [12*NUM_CH-1:0]    adc_data,
  output logic [NUM_CH-1:0]       line_bits,
  output logic                    scan_done,
  output logic                    busy
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;

  // One counter serves both SHIFT (0..31) and GAP (0..GAP_CYC-1).
  localparam int unsigned      CNT_W      = (GAP_CYC > 32) ? $clog2(GAP_CYC) : 5;
  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(31);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
  localparam logic [2:0]       LAST_CH    = 3'(NUM_CH - 1);

  state_e                state_q,     state_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;
  logic [2:0]            addr_ptr_q,  addr_ptr_d;
  logic [2:0]            send_addr_q, send_addr_d;
  logic [2:0]            conv_ch_q,   conv_ch_d;
  logic                  primed_q,    primed_d;
  // Only the last 12 bits of a frame matter; the 4 leading zeros are
  // shifted out of the top of this register and never stored.
  logic [11:0]           shreg_q,     shreg_d;
  logic                  sclk_q,      sclk_d;
  logic                  cs_q,        cs_d;
  logic                  din_q,       din_d;
  logic [12*NUM_CH-1:0]  adc_data_q,  adc_data_d;
  logic [NUM_CH-1:0]     line_bits_q, line_bits_d;
  logic                  scan_done_q, scan_done_d;
  logic                  busy_q,      busy_d;

  // Address bits go out MSB first on SCLK falls of bit slots 2, 3 and 4.
  function automatic logic addr_bit(input logic [2:0] addr, input logic [3:0] b);
    case (b)
      4'd2:    return addr[2];
      4'd3:    return addr[1];
      4'd4:    return addr[0];
      default: return 1'b0;
    endcase
  endfunction

  // Next-state and next-output logic. Outputs are computed for the state
  // being entered, so every port comes straight from a flop.
  always_comb begin
    // NOTE: every _d starts from its _q (or an inactive value) so that a
    // branch that does not mention a signal holds it instead of inferring a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_ptr_d  = addr_ptr_q;
    send_addr_d = send_addr_q;
    conv_ch_d   = conv_ch_q;
    primed_d    = primed_q;
    shreg_d     = shreg_q;
    sclk_d      = sclk_q;
    cs_d        = cs_q;
    din_d       = din_q;
    adc_data_d  = adc_data_q;
    line_bits_d = line_bits_q;
    scan_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d     = SETUP;
          cs_d        = 1'b0;
          send_addr_d = addr_ptr_q;
        end
      end

      SETUP: begin
        state_d = SHIFT;
        cnt_d   = '0;
        sclk_d  = 1'b0;
        din_d   = 1'b0;
      end

      SHIFT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!cnt_q[0]) begin
          // Rising SCLK: DOUT has had half an SCLK period to settle.
          sclk_d  = 1'b1;
          shreg_d = {shreg_q[10:0], dout};
        end else if (cnt_q != SHIFT_LAST) begin
          // Falling SCLK for the next bit slot; DIN holds through the rise.
          sclk_d = 1'b0;
          din_d  = addr_bit(send_addr_q, cnt_q[4:1] + 4'd1);
        end else begin
          state_d = HOLD;
          cs_d    = 1'b1;
          sclk_d  = 1'b1;
          din_d   = 1'b0;
          if (primed_q) begin
            for (int i = 0; i < NUM_CH; i++) begin
              if (conv_ch_q == 3'(i)) adc_data_d[12*i +: 12] = shreg_q;
            end
            scan_done_d = (conv_ch_q == LAST_CH);
          end else begin
            primed_d = 1'b1;
          end
          conv_ch_d  = send_addr_q;
          addr_ptr_d = (addr_ptr_q == LAST_CH) ? 3'd0 : addr_ptr_q + 3'd1;
        end
      end

      HOLD: begin
        state_d = GAP;
        cnt_d   = '0;
      end

      GAP: begin
        if (cnt_q == GAP_LAST) begin
          if (enable) begin
            state_d     = SETUP;
            cs_d        = 1'b0;
            send_addr_d = addr_ptr_q;
          end else begin
            state_d    = IDLE;
            primed_d   = 1'b0;
            addr_ptr_d = 3'd0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    // Line bits refresh together with the final slot of a scan, using the
    // value being stored in this same cycle.
    if (scan_done_d) begin
      for (int i = 0; i < NUM_CH; i++) begin
        line_bits_d[i] = (adc_data_d[12*i +: 12] > THRESH);
      end
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_ptr_q  <= 3'd0;
      send_addr_q <= 3'd0;
      conv_ch_q   <= 3'd0;
      primed_q    <= 1'b0;
      shreg_q     <= '0;
      sclk_q      <= 1'b1;
      cs_q        <= 1'b1;
      din_q       <= 1'b0;
      // NOTE: the result slots are plain flops, not a RAM, so they can be
      // and are cleared by reset like the rest of the state.
      adc_data_q  <= '0;
      line_bits_q <= '0;
      scan_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values computed above, independent of statement order.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_ptr_q  <= addr_ptr_d;
      send_addr_q <= send_addr_d;
      conv_ch_q   <= conv_ch_d;
      primed_q    <= primed_d;
      shreg_q     <= shreg_d;
      sclk_q      <= sclk_d;
      cs_q        <= cs_d;
      din_q       <= din_d;
      adc_data_q  <= adc_data_d;
      line_bits_q <= line_bits_d;
      scan_done_q <= scan_done_d;
      busy_q      <= busy_d;
    end
  end

  assign sclk      = sclk_q;
  assign cs        = cs_q;
  assign din       = din_q;
  assign adc_data  = adc_data_q;
  assign line_bits = line_bits_q;
  assign scan_done = scan_done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer with a behavioural ADC128S022 model.
// The model converts the channel addressed in the previous frame and shifts
// {4'b0, value} out MSB first on SCLK falls.

module tb_adc_scan_sequencer;

  localparam int NUM_CH = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 enable;
  logic                 sclk;
  logic                 cs;
  logic                 din;
  logic                 dout = 1'b0;
  logic [12*NUM_CH-1:0] adc_data;
  logic [NUM_CH-1:0]    line_bits;
  logic                 scan_done;
  logic                 busy;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  logic [11:0] val [8];

  always #5 clk = ~clk;

  adc_scan_sequencer #(
    .NUM_CH (NUM_CH),
    .THRESH (12'd2048),
    .GAP_CYC(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .sclk     (sclk),
    .cs       (cs),
    .din      (din),
    .dout     (dout),
    .adc_data (adc_data),
    .line_bits(line_bits),
    .scan_done(scan_done),
    .busy     (busy)
  );

  // ADC model
  logic        cs_prev   = 1'b1;
  logic        sclk_prev = 1'b1;
  int          fall_cnt  = 0;
  int          rise_cnt  = 0;
  logic [2:0]  addr_cap  = 3'd0;
  logic [2:0]  conv_m    = 3'd0;
  logic [15:0] word      = 16'd0;

  always @(cs or sclk) begin
    if (cs_prev === 1'b1 && cs === 1'b0) begin
      fall_cnt = 0;
      rise_cnt = 0;
      addr_cap = 3'd0;
      word     = {4'b0000, val[conv_m]};
    end
    if (cs_prev === 1'b0 && cs === 1'b1) conv_m = addr_cap;
    if (cs === 1'b0 && sclk_prev === 1'b1 && sclk === 1'b0) begin
      if (fall_cnt < 16) dout = word[15-fall_cnt];
      fall_cnt++;
    end
    if (cs === 1'b0 && sclk_prev === 1'b0 && sclk === 1'b1) begin
      if (rise_cnt >= 2 && rise_cnt <= 4) addr_cap = {addr_cap[1:0], din};
      rise_cnt++;
    end
    cs_prev   = cs;
    sclk_prev = sclk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until scan_done is seen, bounded; the latency itself is checked.
  task automatic run_to_scan_done(input int expected, input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (scan_done !== 1'b1 && n < 400);
    check(tag, 64'(n), 64'(expected));
  endtask

  // Four GAP cycles following a HOLD.
  task automatic gap_check();
    for (int g = 0; g < 4; g++) begin
      tick();
      check("gap_cs", 64'(cs), 64'd1);
      check("gap_sclk", 64'(sclk), 64'd1);
      check("gap_scan_done", 64'(scan_done), 64'd0);
      check("gap_busy", 64'(busy), 64'd1);
    end
  endtask

  // SETUP, 32 SHIFT cycles and the HOLD entry of one frame sending address a.
  task automatic check_frame(input logic [2:0] a);
    logic exp_din;
    int   b;
    tick();
    check("setup_cs", 64'(cs), 64'd0);
    check("setup_sclk", 64'(sclk), 64'd1);
    for (int c = 0; c < 32; c++) begin
      tick();
      b       = c / 2;
      exp_din = (b >= 2 && b <= 4) ? a[4-b] : 1'b0;
      check("shift_cs", 64'(cs), 64'd0);
      check("shift_sclk", 64'(sclk), 64'(c % 2));
      check("shift_din", 64'(din), 64'(exp_din));
    end
    tick();
    check("hold_cs", 64'(cs), 64'd1);
    check("hold_sclk", 64'(sclk), 64'd1);
  endtask

  initial begin
    rst    = 1'b1;
    enable = 1'b0;
    for (int i = 0; i < 8; i++) val[i] = 12'd0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_cs", 64'(cs), 64'd1);
    check("rst_sclk", 64'(sclk), 64'd1);
    check("rst_din", 64'(din), 64'd0);
    check("rst_adc_data", 64'(adc_data), 64'd0);
    check("rst_line_bits", 64'(line_bits), 64'd0);
    check("rst_scan_done", 64'(scan_done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);

    // First scan: priming frame, then first scan_done in HOLD of frame 5
    val[0] = 12'd100; val[1] = 12'd1000; val[2] = 12'd3000; val[3] = 12'd4000;
    rst    = 1'b0;
    enable = 1'b1;
    run_to_scan_done(186, "first_scan_latency");
    check("scan1_adc_data", 64'(adc_data), 64'({12'd4000, 12'd3000, 12'd1000, 12'd100}));
    check("scan1_line_bits", 64'(line_bits), 64'(4'b1100));
    check("scan1_busy", 64'(busy), 64'd1);

    // Second scan: full-scale, zero, exactly-threshold and threshold+1
    val[0] = 12'hFFF; val[1] = 12'h000; val[2] = 12'd2048; val[3] = 12'd2049;
    tick();
    check("scan1_pulse_width", 64'(scan_done), 64'd0);
    run_to_scan_done(151, "scan2_period");
    check("scan2_adc_data", 64'(adc_data), 64'({12'd2049, 12'd2048, 12'h000, 12'hFFF}));
    check("scan2_line_bits", 64'(line_bits), 64'(4'b1001));

    // Third scan: ch2 moves from 2048 to 2049
    val[0] = 12'd1; val[1] = 12'd2047; val[2] = 12'd2049; val[3] = 12'd2048;
    tick();
    check("scan2_pulse_width", 64'(scan_done), 64'd0);
    run_to_scan_done(151, "scan3_period");
    check("scan3_adc_data", 64'(adc_data), 64'({12'd2048, 12'd2049, 12'd2047, 12'd1}));
    check("scan3_line_bits", 64'(line_bits), 64'(4'b0100));

    // Waveform of the next four frames: addresses 1,2,3,0
    gap_check(); check_frame(3'd1);
    gap_check(); check_frame(3'd2);
    gap_check(); check_frame(3'd3);
    gap_check(); check_frame(3'd0);
    check("scan4_scan_done", 64'(scan_done), 64'd1);
    check("scan4_adc_data", 64'(adc_data), 64'({12'd2048, 12'd2049, 12'd2047, 12'd1}));

    // Asynchronous reset at bit 10 (phase 0) of a SHIFT
    gap_check();
    tick();
    repeat (21) tick();
    check("pre_rst_cs", 64'(cs), 64'd0);
    check("pre_rst_sclk", 64'(sclk), 64'd0);
    #2 rst = 1'b1;
    #1;
    check("arst_cs", 64'(cs), 64'd1);
    check("arst_sclk", 64'(sclk), 64'd1);
    check("arst_din", 64'(din), 64'd0);
    check("arst_adc_data", 64'(adc_data), 64'd0);
    check("arst_line_bits", 64'(line_bits), 64'd0);
    check("arst_scan_done", 64'(scan_done), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_to_scan_done(186, "post_rst_latency");
    check("post_rst_adc_data", 64'(adc_data), 64'({12'd2048, 12'd2049, 12'd2047, 12'd1}));
    check("post_rst_line_bits", 64'(line_bits), 64'(4'b0100));

    // enable dropped at bit 7 of frame 3
    val[0] = 12'h123; val[1] = 12'hABC; val[2] = 12'h800; val[3] = 12'h801;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (92) tick();
    check("f3_bit7_cs", 64'(cs), 64'd0);
    check("f3_bit7_sclk", 64'(sclk), 64'd0);
    enable = 1'b0;
    repeat (18) tick();
    check("f3_hold_cs", 64'(cs), 64'd1);
    check("f3_hold_adc_data", 64'(adc_data), 64'({12'h000, 12'h000, 12'hABC, 12'h123}));
    check("f3_hold_scan_done", 64'(scan_done), 64'd0);
    check("f3_hold_busy", 64'(busy), 64'd1);
    repeat (4) tick();
    check("gap_end_busy", 64'(busy), 64'd1);
    tick();
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_cs", 64'(cs), 64'd1);
    check("idle_sclk", 64'(sclk), 64'd1);
    repeat (5) tick();
    check("idle_hold_busy", 64'(busy), 64'd0);
    check("idle_hold_cs", 64'(cs), 64'd1);
    check("idle_hold_adc_data", 64'(adc_data), 64'({12'h000, 12'h000, 12'hABC, 12'h123}));
    check("idle_hold_line_bits", 64'(line_bits), 64'd0);

    // Re-enable: priming frame sends address 0 and stores nothing
    val[0] = 12'h456;
    enable = 1'b1;
    check_frame(3'd0);
    check("reprime_adc_data", 64'(adc_data), 64'({12'h000, 12'h000, 12'hABC, 12'h123}));
    check("reprime_scan_done", 64'(scan_done), 64'd0);
    gap_check();
    check_frame(3'd1);
    check("restore_ch0_adc_data", 64'(adc_data), 64'({12'h000, 12'h000, 12'hABC, 12'h456}));

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
